// File: rtl/pc_pkg.sv
// Shared types and constants for the fetch-PC slice.
package pc_pkg;

    // Fetch FSM states.
    typedef enum logic [1:0] {
        PC_BOOT  = 2'd0,
        PC_FETCH = 2'd1,
        PC_STALL = 2'd2
    } pc_state_e;

    // What, if anything, is parked in the pending-redirect buffer.
    typedef enum logic [1:0] {
        PEND_NONE  = 2'd0,
        PEND_REDIR = 2'd1,
        PEND_TRAP  = 2'd2
    } pend_kind_e;

    // Sequential fetch stride in bytes.
    localparam int PC_INC = 4;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux and target alignment check (generalised pc_add4).
// Priority: trap > aligned redirect > pending buffer > pc+4 on advance > hold.
module pc_next_sel
    import pc_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int IALIGN = 4
) (
    input  logic [XLEN-1:0] pc,
    input  logic            advance,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_base,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            pend_valid,
    input  logic [XLEN-1:0] pend_addr,
    output logic [XLEN-1:0] next_pc,
    output logic            take,
    output logic            misaligned
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);
    localparam logic [XLEN-1:0] TRAP_MASK  = ~XLEN'(3);

    logic target_ok;
    logic redir_take;

    // Select the next PC and flag a misaligned redirect unless a trap hides it.
    always_comb begin
        target_ok  = ((redirect_target & ALIGN_MASK) == '0);
        redir_take = redirect_valid && target_ok;
        misaligned = redirect_valid && !target_ok && !trap_valid;
        next_pc    = pc;
        take       = 1'b0;
        if (trap_valid) begin
            next_pc = trap_base & TRAP_MASK;
            take    = 1'b1;
        end else if (redir_take) begin
            next_pc = redirect_target;
            take    = 1'b1;
        end else if (pend_valid) begin
            next_pc = pend_addr;
            take    = 1'b1;
        end else if (advance) begin
            next_pc = pc + XLEN'(PC_INC);
            take    = 1'b1;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC register with valid/ready request issue, stall handling,
// buffered redirects/traps while a request is stalled by memory, and
// misaligned-redirect reporting.
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              IALIGN       = 4,
    parameter int              CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic             redirect_valid_i,
    input  logic [XLEN-1:0]  redirect_target_i,
    input  logic             trap_valid_i,
    input  logic [XLEN-1:0]  trap_base_i,
    output logic             req_valid_o,
    input  logic             req_ready_i,
    output logic [XLEN-1:0]  pc_o,
    output logic             misalign_o,
    output logic [XLEN-1:0]  misalign_addr_o,
    output logic [CNT_W-1:0] fetch_count_o
);

    pc_state_e       state;
    pend_kind_e      pend_kind;
    logic [XLEN-1:0] pend_addr;

    logic            fire;
    logic            update;
    logic [XLEN-1:0] sel_next_pc;
    logic            sel_take;
    logic            sel_misaligned;

    // PC may only move when no request is being held against a busy memory.
    assign fire   = req_valid_o && req_ready_i;
    assign update = fire || (state != PC_FETCH);

    pc_next_sel #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_next_sel (
        .pc              (pc_o),
        .advance         (fire),
        .trap_valid      (trap_valid_i),
        .trap_base       (trap_base_i),
        .redirect_valid  (redirect_valid_i),
        .redirect_target (redirect_target_i),
        .pend_valid      (pend_kind != PEND_NONE),
        .pend_addr       (pend_addr),
        .next_pc         (sel_next_pc),
        .take            (sel_take),
        .misaligned      (sel_misaligned)
    );

    // Fetch FSM with registered request-valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= PC_BOOT;
            req_valid_o <= 1'b0;
        end else begin
            case (state)
                PC_BOOT: begin
                    state       <= PC_FETCH;
                    req_valid_o <= 1'b1;
                end
                PC_FETCH: begin
                    if (fire && stall_i) begin
                        state       <= PC_STALL;
                        req_valid_o <= 1'b0;
                    end
                end
                PC_STALL: begin
                    if (!stall_i) begin
                        state       <= PC_FETCH;
                        req_valid_o <= 1'b1;
                    end
                end
                default: begin
                    state       <= PC_BOOT;
                    req_valid_o <= 1'b0;
                end
            endcase
        end
    end

    // PC, pending buffer, misalign report and handshake counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_o            <= RESET_VECTOR;
            pend_kind       <= PEND_NONE;
            pend_addr       <= '0;
            misalign_o      <= 1'b0;
            misalign_addr_o <= '0;
            fetch_count_o   <= '0;
        end else begin
            misalign_o <= sel_misaligned;
            if (sel_misaligned) begin
                misalign_addr_o <= redirect_target_i;
            end
            if (fire) begin
                fetch_count_o <= fetch_count_o + CNT_W'(1);
            end
            if (update) begin
                if (sel_take) begin
                    pc_o <= sel_next_pc;
                end
                pend_kind <= PEND_NONE;
            end else if (trap_valid_i) begin
                // Request outstanding: park the trap; it always wins the buffer.
                pend_kind <= PEND_TRAP;
                pend_addr <= sel_next_pc;
            end else if (redirect_valid_i && !sel_misaligned && (pend_kind != PEND_TRAP)) begin
                // A redirect may replace an older redirect but never a parked trap.
                pend_kind <= PEND_REDIR;
                pend_addr <= sel_next_pc;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: per-cycle vector table plus a fetch-address scoreboard.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_target_i;
    logic        trap_valid_i;
    logic [31:0] trap_base_i;
    logic        req_ready_i;

    logic        req_valid_o;
    logic [31:0] pc_o;
    logic        misalign_o;
    logic [31:0] misalign_addr_o;
    logic [15:0] fetch_count_o;

    logic        req_valid_2;
    logic [31:0] pc_2;
    logic        misalign_2;
    logic [31:0] misalign_addr_2;
    logic [15:0] fetch_count_2;

    pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .redirect_valid_i(redirect_valid_i), .redirect_target_i(redirect_target_i),
        .trap_valid_i(trap_valid_i), .trap_base_i(trap_base_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .pc_o(pc_o),
        .misalign_o(misalign_o), .misalign_addr_o(misalign_addr_o),
        .fetch_count_o(fetch_count_o)
    );

    // Same stimulus, but 2-byte alignment: 0x102 is a legal target here.
    pc_fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(2), .CNT_W(16)) dut2 (
        .clk(clk), .rst(rst), .stall_i(stall_i),
        .redirect_valid_i(redirect_valid_i), .redirect_target_i(redirect_target_i),
        .trap_valid_i(trap_valid_i), .trap_base_i(trap_base_i),
        .req_valid_o(req_valid_2), .req_ready_i(req_ready_i), .pc_o(pc_2),
        .misalign_o(misalign_2), .misalign_addr_o(misalign_addr_2),
        .fetch_count_o(fetch_count_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        rdy;
        logic        rv;
        logic [31:0] rt;
        logic        tv;
        logic [31:0] tb;
        logic        ev;
        logic [31:0] epc;
        logic        emis;
        logic [31:0] emaddr;
        logic [15:0] ecnt;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          row      = -1;

    function automatic vec_t mk(logic r, logic s, logic rd, logic rv, logic [31:0] rt,
                                logic tv, logic [31:0] tb, logic ev, logic [31:0] epc,
                                logic em, logic [31:0] ema, logic [15:0] ec);
        vec_t v;
        v.rst = r; v.stall = s; v.rdy = rd; v.rv = rv; v.rt = rt; v.tv = tv; v.tb = tb;
        v.ev = ev; v.epc = epc; v.emis = em; v.emaddr = ema; v.ecnt = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%h expected=%h", name, row, act, exp);
        end
    endtask

    // Scoreboard: every handshake must present the next expected fetch address.
    always @(negedge clk) begin
        if (rst && req_valid_o && req_ready_i) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_fire", pc_o, 32'hxxxx_xxxx);
            end else begin
                chk("sb_fetch_addr", pc_o, sb.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b0; stall_i = 1'b0; redirect_valid_i = 1'b0; redirect_target_i = '0;
        trap_valid_i = 1'b0; trap_base_i = '0; req_ready_i = 1'b0;

        //            rst st rdy rv  rt            tv tb            ev epc           mis maddr      cnt
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,         0, 32'h0,        0, 32'h0,   0));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0, 32'h0,         0, 32'h0,        0, 32'h0,   0));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0, 32'h0,         1, 32'h0,        0, 32'h0,   0));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0, 32'h0,         1, 32'h4,        0, 32'h0,   1));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0, 32'h0,         1, 32'h8,        0, 32'h0,   2));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0, 32'h0,         1, 32'hC,        0, 32'h0,   3));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(1, 0, 0, 0, 32'h0,    0, 32'h0,         1, 32'h10,       0, 32'h0,   4));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0, 32'h0,         1, 32'h10,       0, 32'h0,   4));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0, 32'h0,         1, 32'h14,       0, 32'h0,   5));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0, 32'h0,         1, 32'h18,       0, 32'h0,   6));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0, 32'h0,         1, 32'h1C,       0, 32'h0,   7));
        vecs.push_back(mk(1, 0, 0, 1, 32'h100,      0, 32'h0,         1, 32'h20,       0, 32'h0,   8));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h20,       0, 32'h0,   8));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h20,       0, 32'h0,   8));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0, 32'h0,         1, 32'h20,       0, 32'h0,   8));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0, 32'h0,         1, 32'h100,      0, 32'h0,   9));
        vecs.push_back(mk(1, 0, 0, 1, 32'h200,      0, 32'h0,         1, 32'h104,      0, 32'h0,  10));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        1, 32'h8000_0003, 1, 32'h104,      0, 32'h0,  10));
        vecs.push_back(mk(1, 0, 0, 1, 32'h300,      0, 32'h0,         1, 32'h104,      0, 32'h0,  10));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0, 32'h0,         1, 32'h104,      0, 32'h0,  10));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0, 32'h0,         1, 32'h8000_0000,0, 32'h0,  11));
        vecs.push_back(mk(1, 0, 1, 1, 32'h102,      0, 32'h0,         1, 32'h8000_0004,0, 32'h0,  12));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0, 32'h0,         1, 32'h8000_0008,1, 32'h102,13));
        vecs.push_back(mk(1, 1, 1, 0, 32'h0,        0, 32'h0,         1, 32'h8000_000C,0, 32'h102,14));
        vecs.push_back(mk(1, 1, 1, 1, 32'h400,      0, 32'h0,         0, 32'h8000_0010,0, 32'h102,15));
        vecs.push_back(mk(1, 1, 1, 0, 32'h0,        0, 32'h0,         0, 32'h400,      0, 32'h102,15));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0, 32'h0,         0, 32'h400,      0, 32'h102,15));
        vecs.push_back(mk(1, 0, 1, 1, 32'hFFFF_FFFC,0, 32'h0,         1, 32'h400,      0, 32'h102,15));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0, 32'h0,         1, 32'hFFFF_FFFC,0, 32'h102,16));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0, 32'h0,         1, 32'h0,        0, 32'h102,17));
        vecs.push_back(mk(1, 0, 0, 1, 32'h500,      0, 32'h0,         1, 32'h4,        0, 32'h102,18));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h4,        0, 32'h102,18));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,         0, 32'h0,        0, 32'h0,   0));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0, 32'h0,         0, 32'h0,        0, 32'h0,   0));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0, 32'h0,         1, 32'h0,        0, 32'h0,   0));
        vecs.push_back(mk(1, 0, 1, 1, 32'h102,      1, 32'h600,       1, 32'h4,        0, 32'h0,   1));
        vecs.push_back(mk(1, 0, 1, 0, 32'h0,        0, 32'h0,         1, 32'h600,      0, 32'h0,   2));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,         1, 32'h604,      0, 32'h0,   3));

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            row               = i;
            rst               = vecs[i].rst;
            stall_i           = vecs[i].stall;
            req_ready_i       = vecs[i].rdy;
            redirect_valid_i  = vecs[i].rv;
            redirect_target_i = vecs[i].rt;
            trap_valid_i      = vecs[i].tv;
            trap_base_i       = vecs[i].tb;
            if (vecs[i].rst && vecs[i].rdy && vecs[i].ev)
                sb.push_back(vecs[i].epc);
            @(negedge clk);
            chk("req_valid",     {31'b0, req_valid_o}, {31'b0, vecs[i].ev});
            chk("pc",            pc_o,                 vecs[i].epc);
            chk("misalign",      {31'b0, misalign_o},  {31'b0, vecs[i].emis});
            chk("misalign_addr", misalign_addr_o,      vecs[i].emaddr);
            chk("fetch_count",   {16'b0, fetch_count_o}, {16'b0, vecs[i].ecnt});
            // Cycle after the 0x102 redirect: the IALIGN=2 instance took it.
            if (redirect_target_i == 32'h0 && i > 0 && vecs[i-1].rt == 32'h102 && !vecs[i-1].tv) begin
                chk("ialign2_pc",        pc_2,                 32'h102);
                chk("ialign2_misalign",  {31'b0, misalign_2},  32'h0);
                chk("ialign2_maddr",     misalign_addr_2,      32'h0);
                chk("ialign2_valid",     {31'b0, req_valid_2}, 32'h1);
                chk("ialign2_count",     {16'b0, fetch_count_2}, 32'd13);
            end
        end

        @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
